// File: rtl/countdown_timer_if.sv
// countdown_timer_if
//   CPU data-bus slice seen by the countdown timer.
//   master : CPU side, drives address, strobes and write data.
//   slave  : timer side, returns registered read data, hit and irq.
//   Signals:
//     mem_addr  byte address (ADDR_WIDTH bits)
//     rd_mem    explicit data read (informational)
//     wr_mem    write strobe
//     byt       1 = byte access, 0 = 16-bit access
//     wr_data   write data, odd-byte data in [15:8]
//     rd_data   registered read word, 0 when not addressed
//     hit       registered: rd_data belongs to this block
//     irq       interrupt request (IF & IE)
interface countdown_timer_if #(
   parameter int unsigned ADDR_WIDTH = 12
);
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  rd_mem;
   logic                  wr_mem;
   logic                  byt;
   logic [15:0]           wr_data;
   logic [15:0]           rd_data;
   logic                  hit;
   logic                  irq;

   modport master (
      output mem_addr, rd_mem, wr_mem, byt, wr_data,
      input  rd_data, hit, irq
   );

   modport slave (
      input  mem_addr, rd_mem, wr_mem, byt, wr_data,
      output rd_data, hit, irq
   );
endinterface

// File: rtl/countdown_timer.sv
// countdown_timer
//   Memory-mapped millisecond countdown timer with interrupt flag.
//   Register map (byte addresses):
//     002h/003h  count  16-bit down counter, decremented once per tick
//     004h       ctrl   bit0 IF (write-0-to-clear), bit1 IE
//     005h       ctrl upper byte, reads 0, byte writes ignored
//   Ports:
//     clk   clock
//     rst   asynchronous active-high reset
//     bus   countdown_timer_if slave: mem_addr/rd_mem/wr_mem/byt/wr_data in,
//           rd_data/hit/irq out
//   Parameters:
//     CLOCK_HZ / TICK_HZ  prescaler ratio P (must be >= 2)
//     ADDR_WIDTH          width of mem_addr
module countdown_timer #(
   parameter int unsigned CLOCK_HZ   = 27_000_000,
   parameter int unsigned TICK_HZ    = 1000,
   parameter int unsigned ADDR_WIDTH = 12
) (
   input logic              clk,
   input logic              rst,
   countdown_timer_if.slave bus
);
   localparam int unsigned      P      = CLOCK_HZ / TICK_HZ;
   localparam int unsigned      PW     = $clog2(P);
   localparam logic [PW-1:0]    P_LAST = PW'(P - 1);

   logic [PW-1:0] presc;
   logic [15:0]   count;
   logic          if_flag;
   logic          ie;
   logic [15:0]   rd_data_q;
   logic          hit_q;

   logic [ADDR_WIDTH-3:0] page;
   logic                  sel_cnt;
   logic                  sel_ctl;
   logic                  odd;
   logic                  wr_lo;
   logic                  wr_hi;
   logic                  wr_ctl;
   logic                  cnt_wr;
   logic                  tick;
   logic                  if_set;
   logic [15:0]           count_next;
   logic                  if_next;
   logic [15:0]           rd_next;
   logic                  rd_mem_unused;

   // Reads have no side effects, so the explicit read strobe is not needed.
   assign rd_mem_unused = bus.rd_mem;

   // 002h/003h share page 0 with addr[1]=1; 004h/005h are page 1 with addr[1]=0.
   assign page    = bus.mem_addr[ADDR_WIDTH-1:2];
   assign sel_cnt = (page == '0) && bus.mem_addr[1];
   assign sel_ctl = (page == (ADDR_WIDTH-2)'(1)) && !bus.mem_addr[1];
   assign odd     = bus.mem_addr[0];

   // A word access at an odd address is treated as the aligned word.
   assign wr_lo  = bus.wr_mem && sel_cnt && (!bus.byt || !odd);
   assign wr_hi  = bus.wr_mem && sel_cnt && (!bus.byt || odd);
   assign wr_ctl = bus.wr_mem && sel_ctl && (!bus.byt || !odd);
   assign cnt_wr = wr_lo || wr_hi;

   assign tick   = (presc == P_LAST);
   // A count write in the tick cycle drops the decrement, so it cannot expire.
   assign if_set = tick && !cnt_wr && (count == 16'd1);

   always_comb begin
      count_next = count;
      if (cnt_wr) begin
         if (wr_lo) count_next[7:0]  = bus.wr_data[7:0];
         if (wr_hi) count_next[15:8] = bus.wr_data[15:8];
      end else if (tick && (count != '0)) begin
         count_next = count - 16'd1;
      end
   end

   // Hardware set takes priority over the software write-0-to-clear.
   always_comb begin
      if_next = if_flag;
      if (if_set)
         if_next = 1'b1;
      else if (wr_ctl)
         if_next = if_flag & bus.wr_data[0];
   end

   always_comb begin
      rd_next = '0;
      if (sel_cnt)
         rd_next = count;
      else if (sel_ctl)
         rd_next = {14'd0, ie, if_flag};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc     <= '0;
         count     <= '0;
         if_flag   <= 1'b0;
         ie        <= 1'b0;
         rd_data_q <= '0;
         hit_q     <= 1'b0;
      end else begin
         presc     <= (cnt_wr || tick) ? '0 : presc + 1'b1;
         count     <= count_next;
         if_flag   <= if_next;
         if (wr_ctl)
            ie <= bus.wr_data[1];
         rd_data_q <= rd_next;
         hit_q     <= sel_cnt || sel_ctl;
      end
   end

   assign bus.rd_data = rd_data_q;
   assign bus.hit     = hit_q;
   assign bus.irq     = if_flag & ie;
endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;
   localparam int unsigned P = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;

   countdown_timer_if #(.ADDR_WIDTH(12)) bus ();

   countdown_timer #(
      .CLOCK_HZ   (8),
      .TICK_HZ    (1),
      .ADDR_WIDTH (12)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [11:0] addr;
      logic        wr;
      logic        byt;
      logic [15:0] wdata;
      logic [15:0] rd;
      logic        hit;
      logic        irq;
   } vec_t;

   vec_t tbl [19];

   // reference model state
   int unsigned m_count;
   int unsigned m_since;
   bit          m_if;
   bit          m_ie;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [11:0] a, input logic wr, input logic b, input logic [15:0] d);
      bus.mem_addr = a;
      bus.wr_mem   = wr;
      bus.byt      = b;
      bus.wr_data  = d;
      bus.rd_mem   = !wr;
   endtask

   task automatic cycle(input logic [11:0] a, input logic wr, input logic b, input logic [15:0] d);
      drive(a, wr, b, d);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(12'h000, 1'b0, 1'b0, 16'h0000);
   endtask

   task automatic check_out(input string name, input logic [15:0] rd, input logic hit, input logic irq);
      chk({name, ".rd"},  bus.rd_data, rd);
      chk({name, ".hit"}, 16'(bus.hit), 16'(hit));
      chk({name, ".irq"}, 16'(bus.irq), 16'(irq));
   endtask

   function automatic logic [15:0] seq_a_count(input int j);
      if (j < 8)  return 16'd3;
      if (j < 16) return 16'd2;
      if (j < 24) return 16'd1;
      return 16'd0;
   endfunction

   task automatic model_reset();
      m_count = 0;
      m_since = 0;
      m_if    = 1'b0;
      m_ie    = 1'b0;
   endtask

   // One clock of the timer, straight from the register-map rules.
   task automatic model_step(input logic [11:0] a, input logic wr, input logic b,
                             input logic [15:0] d, output logic [15:0] erd, output logic ehit);
      bit in_cnt, in_ctl, tick, lo, hi, cwr, set;
      in_cnt = (a == 12'h002) || (a == 12'h003);
      in_ctl = (a == 12'h004) || (a == 12'h005);
      ehit   = in_cnt || in_ctl;
      erd    = in_cnt ? 16'(m_count) : (in_ctl ? {14'd0, m_ie, m_if} : 16'h0000);
      tick   = (m_since == P - 1);
      lo     = wr && in_cnt && (!b || a == 12'h002);
      hi     = wr && in_cnt && (!b || a == 12'h003);
      cwr    = wr && ((a == 12'h004) || (a == 12'h005 && !b));
      set    = 1'b0;
      if (lo || hi) begin
         if (lo) m_count = (m_count & 32'hFF00) | 32'(d[7:0]);
         if (hi) m_count = (m_count & 32'h00FF) | (32'(d) & 32'hFF00);
         m_since = 0;
      end else if (tick) begin
         if (m_count == 1) set = 1'b1;
         if (m_count > 0) m_count = m_count - 1;
         m_since = 0;
      end else begin
         m_since = m_since + 1;
      end
      if (cwr) m_ie = d[1];
      if (set)      m_if = 1'b1;
      else if (cwr) m_if = m_if & d[0];
   endtask

   initial begin
      logic [15:0] erd;
      logic        ehit;
      logic [11:0] a;
      logic [15:0] d;
      logic        wr, b;

      tbl[0]  = '{12'h002, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0};
      tbl[1]  = '{12'h004, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0};
      tbl[2]  = '{12'h000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
      tbl[3]  = '{12'h006, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
      tbl[4]  = '{12'h002, 1'b1, 1'b0, 16'hABCD, 16'h0000, 1'b1, 1'b0};
      tbl[5]  = '{12'h002, 1'b0, 1'b0, 16'h0000, 16'hABCD, 1'b1, 1'b0};
      tbl[6]  = '{12'h002, 1'b1, 1'b1, 16'h0034, 16'hABCD, 1'b1, 1'b0};
      tbl[7]  = '{12'h003, 1'b1, 1'b1, 16'h1200, 16'hAB34, 1'b1, 1'b0};
      tbl[8]  = '{12'h003, 1'b0, 1'b0, 16'h0000, 16'h1234, 1'b1, 1'b0};
      tbl[9]  = '{12'h004, 1'b1, 1'b0, 16'h0002, 16'h0000, 1'b1, 1'b0};
      tbl[10] = '{12'h005, 1'b0, 1'b1, 16'h0000, 16'h0002, 1'b1, 1'b0};
      tbl[11] = '{12'h005, 1'b1, 1'b1, 16'h0000, 16'h0002, 1'b1, 1'b0};
      tbl[12] = '{12'h004, 1'b0, 1'b0, 16'h0000, 16'h0002, 1'b1, 1'b0};
      tbl[13] = '{12'h006, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0};
      tbl[14] = '{12'h002, 1'b0, 1'b0, 16'h0000, 16'h1234, 1'b1, 1'b0};
      tbl[15] = '{12'h002, 1'b1, 1'b0, 16'h0000, 16'h1234, 1'b1, 1'b0};
      tbl[16] = '{12'h002, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0};
      tbl[17] = '{12'h004, 1'b1, 1'b0, 16'h0000, 16'h0002, 1'b1, 1'b0};
      tbl[18] = '{12'h004, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0};

      // reset
      drive(12'h000, 1'b0, 1'b0, 16'h0000);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_out("reset", 16'h0000, 1'b0, 1'b0);
      rst = 1'b0;

      // table vectors: one bus cycle each, outputs sampled after its edge
      foreach (tbl[i]) begin
         cycle(tbl[i].addr, tbl[i].wr, tbl[i].byt, tbl[i].wdata);
         check_out($sformatf("tbl%0d", i), tbl[i].rd, tbl[i].hit, tbl[i].irq);
      end

      // countdown 3 -> 0 with interrupt, then hold at 0
      cycle(12'h004, 1'b1, 1'b0, 16'h0002);
      cycle(12'h002, 1'b1, 1'b0, 16'h0003);
      for (int k = 1; k <= 64; k++) begin
         cycle(12'h002, 1'b0, 1'b0, 16'h0000);
         chk($sformatf("cnt_k%0d", k), bus.rd_data, seq_a_count(k - 1));
         chk($sformatf("irq_k%0d", k), 16'(bus.irq), 16'(k >= 24));
      end

      // IF write-0-to-clear
      cycle(12'h004, 1'b1, 1'b0, 16'h0003);
      check_out("if_keep", 16'h0003, 1'b1, 1'b1);
      cycle(12'h004, 1'b0, 1'b0, 16'h0000);
      check_out("if_keep_rd", 16'h0003, 1'b1, 1'b1);
      cycle(12'h004, 1'b1, 1'b0, 16'h0002);
      chk("if_clr.irq", 16'(bus.irq), 16'h0000);
      cycle(12'h004, 1'b0, 1'b0, 16'h0000);
      check_out("if_clr_rd", 16'h0002, 1'b1, 1'b0);

      // count write coinciding with a tick: decrement dropped
      cycle(12'h002, 1'b1, 1'b0, 16'h0005);
      idle(P - 1);
      cycle(12'h002, 1'b1, 1'b0, 16'h0005);
      cycle(12'h002, 1'b0, 1'b0, 16'h0000);
      check_out("wr_tick", 16'h0005, 1'b1, 1'b0);

      // IF set coinciding with a software clear: set wins
      cycle(12'h004, 1'b1, 1'b0, 16'h0002);
      cycle(12'h002, 1'b1, 1'b0, 16'h0001);
      idle(P - 1);
      cycle(12'h004, 1'b1, 1'b0, 16'h0000);
      chk("set_clr.irq", 16'(bus.irq), 16'h0000);
      cycle(12'h004, 1'b0, 1'b0, 16'h0000);
      check_out("set_clr_rd", 16'h0001, 1'b1, 1'b0);
      cycle(12'h004, 1'b1, 1'b0, 16'h0003);
      chk("set_clr_ie.irq", 16'(bus.irq), 16'h0001);

      // asynchronous reset mid-count with IF pending
      cycle(12'h002, 1'b1, 1'b0, 16'h0010);
      cycle(12'h004, 1'b0, 1'b0, 16'h0000);
      check_out("pre_rst", 16'h0003, 1'b1, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check_out("async_rst", 16'h0000, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      cycle(12'h004, 1'b0, 1'b0, 16'h0000);
      check_out("post_rst_ctl", 16'h0000, 1'b1, 1'b0);
      cycle(12'h002, 1'b0, 1'b0, 16'h0000);
      check_out("post_rst_cnt", 16'h0000, 1'b1, 1'b0);
      cycle(12'h006, 1'b0, 1'b0, 16'h0000);
      check_out("post_rst_006", 16'h0000, 1'b0, 1'b0);

      // randomized traffic against the reference model
      rst = 1'b1;
      drive(12'h000, 1'b0, 1'b0, 16'h0000);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 599) == 0) begin
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            model_reset();
            check_out($sformatf("rnd_rst%0d", n), 16'h0000, 1'b0, 1'b0);
         end
         if ($urandom_range(0, 15) < 13) a = 12'($urandom_range(0, 7));
         else                            a = 12'($urandom_range(0, 4095));
         wr = ($urandom_range(0, 3) == 0);
         b  = 1'($urandom_range(0, 1));
         if (a == 12'h002 || a == 12'h003) begin
            d = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 12));
            if (a == 12'h003 && b) d = {d[7:0], d[15:8]};
         end else begin
            d = 16'($urandom);
         end
         model_step(a, wr, b, d, erd, ehit);
         cycle(a, wr, b, d);
         check_out($sformatf("rnd%0d", n), erd, ehit, m_if & m_ie);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
